core_rf_wb_arb: RTL and testbench
=================================

Name: core_rf_wb_arb

Overview:
- Arbitrates the single register-file write port between the ALU writeback stage and the load/store unit (LSU) load-return path.
- LSU returns are buffered in a small FIFO. ALU writes have priority, and a starvation counter forces the FIFO to drain.
- Provides a pending-write lookup so decode can stall on RAW/WAW hazards against buffered loads.
- Sits between the writeback stage and core_reg_file write inputs (we/rd/data).

Parameters:
- FIFO_DEPTH, 2, LSU return buffer entries; power of 2, 2..8.
- MAX_WAIT, 4, cycles a valid FIFO head may be bypassed by ALU writes before forced drain; 1..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alu_we_in  in  1  ALU writeback request
- alu_rd_in  in  5  ALU destination register
- alu_data_in  in  32  ALU result
- alu_stall_out  out  1  ALU writeback must hold; ALU request ignored this cycle
- lsu_valid_in  in  1  load return data valid
- lsu_rd_in  in  5  load destination register
- lsu_data_in  in  32  load data
- lsu_ready_out  out  1  FIFO can accept a load return
- dec_rs1_in  in  5  decode source 1 for hazard lookup
- dec_rs2_in  in  5  decode source 2
- dec_rd_in  in  5  decode destination
- pend_hit_out  out  1  a buffered load targets a nonzero rs1/rs2/rd
- rf_we_out  out  1  register-file write enable (registered)
- rf_rd_out  out  5  register-file write address (registered)
- rf_data_out  out  32  register-file write data (registered)

Behaviour:
- Reset (async, rst_n=0), takes effect immediately regardless of clk:
  - FIFO emptied; wait_cnt=0.
  - rf_we_out=0, rf_rd_out=0, rf_data_out=0.
  - lsu_ready_out=1, alu_stall_out=0, pend_hit_out=0.
  - Reset mid-operation discards all buffered loads; no write is issued for them.
- Enqueue: on a clock edge with lsu_valid_in & lsu_ready_out.
  - rd=0: accepted but not stored (handshake completes, no write issued).
  - rd≠0: stored at the tail.
- lsu_ready_out = !full, derived from registered state only. Enqueue while full is impossible; enqueue while dequeuing is allowed if not full.
- Grant, evaluated each cycle and registered to the rf_* outputs on the next edge (1-cycle latency):
  - force = fifo_nonempty & (wait_cnt == MAX_WAIT).
  - If force: grant the FIFO head. alu_stall_out=1 (combinational from registered state) and alu_we_in is ignored; the upstream stage holds its instruction.
  - Else if alu_we_in & alu_rd_in≠0: grant ALU.
  - Else if fifo_nonempty: grant the FIFO head (dequeue).
  - Else: rf_we_out=0 next cycle.
  - alu_we_in with alu_rd_in=0 is dropped; it consumes no grant and the FIFO head may issue that cycle.
- When rf_we_out=0, rf_rd_out and rf_data_out hold their previous values.
- Minimum LSU-to-RF latency is 2 cycles (enqueue edge, then output edge). There is no bypass path.
- wait_cnt:
  - Resets to 0 when the head is dequeued or the FIFO is empty.
  - Increments by 1 for each cycle the FIFO is nonempty and the head is not granted.
  - Saturates at MAX_WAIT.
- pend_hit_out (combinational): OR over valid entries of (entry.rd == dec_rs1_in | dec_rs2_in | dec_rd_in), with x0 matches masked. The entry being dequeued this cycle still counts.
  - Decode stalls on hit, which guarantees no WAW reorder between ALU and LSU writes.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit or an occupancy counter.
- alu_stall_out never asserts when the FIFO is empty.

Test Plan:
- Reset mid-flight: 2 loads buffered, pulse rst_n low asynchronously between edges -> rf_we_out=0 immediately, lsu_ready_out=1, pend_hit_out=0, no later writes of those loads.
- Idle LSU path: lsu_valid rd=5 data=0xDEADBEEF, no ALU traffic -> rf_we_out=1, rd=5, data=0xDEADBEEF two edges after the handshake.
- ALU priority and starvation (MAX_WAIT=4): load rd=7 buffered, alu_we asserted continuously with rd=3 -> 4 ALU writes, then alu_stall_out=1 for one cycle with the rd=7 write, then ALU resumes.
- Full FIFO (depth 2): 3 back-to-back loads during continuous ALU writes -> lsu_ready_out=0 after 2 accepted; third held until a forced dequeue; FIFO order preserved on write-out.
- x0 handling: alu_we rd=0 while a load rd=9 is buffered -> rd=9 written next cycle; lsu return rd=0 -> accepted, never written, pend_hit_out stays 0.
- Hazard lookup: load rd=12 buffered, dec_rs2_in=12 -> pend_hit_out=1; after rd=12 is written -> pend_hit_out=0; dec_rd_in=0 never hits.

Source files
------------

// File: rtl/core_rf_wb_arb_if.sv
// Writeback arbiter bus: ALU writeback, LSU load return, decode hazard lookup
// and the register-file write port.
interface core_rf_wb_arb_if;
  logic        alu_we_in;
  logic [4:0]  alu_rd_in;
  logic [31:0] alu_data_in;
  logic        alu_stall_out;
  logic        lsu_valid_in;
  logic [4:0]  lsu_rd_in;
  logic [31:0] lsu_data_in;
  logic        lsu_ready_out;
  logic [4:0]  dec_rs1_in;
  logic [4:0]  dec_rs2_in;
  logic [4:0]  dec_rd_in;
  logic        pend_hit_out;
  logic        rf_we_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_data_out;

  modport slave (
    input  alu_we_in, alu_rd_in, alu_data_in,
    input  lsu_valid_in, lsu_rd_in, lsu_data_in,
    input  dec_rs1_in, dec_rs2_in, dec_rd_in,
    output alu_stall_out, lsu_ready_out, pend_hit_out,
    output rf_we_out, rf_rd_out, rf_data_out
  );

  modport master (
    output alu_we_in, alu_rd_in, alu_data_in,
    output lsu_valid_in, lsu_rd_in, lsu_data_in,
    output dec_rs1_in, dec_rs2_in, dec_rd_in,
    input  alu_stall_out, lsu_ready_out, pend_hit_out,
    input  rf_we_out, rf_rd_out, rf_data_out
  );
endinterface

// File: rtl/core_rf_wb_arb.sv
// Register-file write-port arbiter: ALU writes win, buffered load returns drain
// when idle or when the head has waited MAX_WAIT cycles.
module core_rf_wb_arb #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  core_rf_wb_arb_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [3:0]    WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);

  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_wait_cnt;
  logic          r_rf_we;
  logic [4:0]    r_rf_rd;
  logic [31:0]   r_rf_data;

  logic [PW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_force;
  logic          w_alu_req;
  logic          w_enq;
  logic          w_grant_fifo;
  logic          w_grant_alu;
  logic          w_pend_hit;
  logic [AW-1:0] w_head_idx;
  logic [AW-1:0] w_tail_idx;

  // Extra pointer bit distinguishes full from empty; occupancy is the difference.
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (w_count == DEPTH_P);
  assign w_force    = !w_empty && (r_wait_cnt == WAIT_MAX);
  assign w_alu_req  = bus.alu_we_in && (bus.alu_rd_in != 5'd0);
  assign w_enq      = bus.lsu_valid_in && !w_full && (bus.lsu_rd_in != 5'd0);
  assign w_head_idx = r_rd_ptr[AW-1:0];
  assign w_tail_idx = r_wr_ptr[AW-1:0];

  // Write-port grant: forced drain, then ALU, then opportunistic drain.
  always_comb begin
    w_grant_fifo = 1'b0;
    w_grant_alu  = 1'b0;
    if (w_force) begin
      w_grant_fifo = 1'b1;
    end else if (w_alu_req) begin
      w_grant_alu = 1'b1;
    end else if (!w_empty) begin
      w_grant_fifo = 1'b1;
    end else begin
      w_grant_fifo = 1'b0;
      w_grant_alu  = 1'b0;
    end
  end

  // Hazard lookup over occupied slots, including the head leaving this cycle.
  always_comb begin
    logic [AW-1:0] idx;
    logic [4:0]    erd;
    w_pend_hit = 1'b0;
    idx        = '0;
    erd        = 5'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = w_head_idx + AW'(i);
      erd = r_fifo_rd[idx];
      if ((PW'(i) < w_count) && (erd != 5'd0) &&
          (((erd == bus.dec_rs1_in) && (bus.dec_rs1_in != 5'd0)) ||
           ((erd == bus.dec_rs2_in) && (bus.dec_rs2_in != 5'd0)) ||
           ((erd == bus.dec_rd_in)  && (bus.dec_rd_in  != 5'd0)))) begin
        w_pend_hit = 1'b1;
      end else begin
        w_pend_hit = w_pend_hit;
      end
    end
  end

  // Load-return storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_rd[w_tail_idx]   <= bus.lsu_rd_in;
      r_fifo_data[w_tail_idx] <= bus.lsu_data_in;
    end
  end

  // Pointers, starvation counter and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wait_cnt <= 4'd0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_data  <= 32'd0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_grant_fifo) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      // A new head always starts its wait from zero.
      if (w_empty || w_grant_fifo) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      if (w_grant_fifo) begin
        r_rf_we   <= 1'b1;
        r_rf_rd   <= r_fifo_rd[w_head_idx];
        r_rf_data <= r_fifo_data[w_head_idx];
      end else if (w_grant_alu) begin
        r_rf_we   <= 1'b1;
        r_rf_rd   <= bus.alu_rd_in;
        r_rf_data <= bus.alu_data_in;
      end else begin
        r_rf_we   <= 1'b0;
      end
    end
  end

  assign bus.lsu_ready_out = !w_full;
  assign bus.alu_stall_out = w_force;
  assign bus.pend_hit_out  = w_pend_hit;
  assign bus.rf_we_out     = r_rf_we;
  assign bus.rf_rd_out     = r_rf_rd;
  assign bus.rf_data_out   = r_rf_data;
endmodule

// File: tb/tb_core_rf_wb_arb.sv
// Self-checking bench for core_rf_wb_arb: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_core_rf_wb_arb;
  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_rf_wb_arb_if bus ();

  core_rf_wb_arb #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: buffered loads, head wait, expected write port.
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  int          m_wait;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  // Expected/observed combinational outputs in the cycle before the last edge.
  logic p_ready, p_stall, p_hit, p_acc;
  logic o_ready, o_stall, o_hit;

  task automatic set_idle();
    bus.alu_we_in    = 1'b0;
    bus.alu_rd_in    = 5'd0;
    bus.alu_data_in  = 32'd0;
    bus.lsu_valid_in = 1'b0;
    bus.lsu_rd_in    = 5'd0;
    bus.lsu_data_in  = 32'd0;
    bus.dec_rs1_in   = 5'd0;
    bus.dec_rs2_in   = 5'd0;
    bus.dec_rd_in    = 5'd0;
  endtask

  task automatic model_clear();
    q_rd.delete();
    q_data.delete();
    m_wait = 0;
    m_we   = 1'b0;
    m_rd   = 5'd0;
    m_data = 32'd0;
  endtask

  // One clock: predict from the rules, sample DUT mid-cycle, advance past the edge.
  task automatic tick();
    int   sz;
    logic pop;
    @(negedge clk);
    sz      = q_rd.size();
    p_ready = (sz < DEPTH);
    p_stall = (sz > 0) && (m_wait == MAXW);
    p_hit   = 1'b0;
    foreach (q_rd[k]) begin
      if (((q_rd[k] == bus.dec_rs1_in) && (bus.dec_rs1_in != 5'd0)) ||
          ((q_rd[k] == bus.dec_rs2_in) && (bus.dec_rs2_in != 5'd0)) ||
          ((q_rd[k] == bus.dec_rd_in)  && (bus.dec_rd_in  != 5'd0)))
        p_hit = 1'b1;
    end
    o_ready = bus.lsu_ready_out;
    o_stall = bus.alu_stall_out;
    o_hit   = bus.pend_hit_out;
    pop = 1'b0;
    if (p_stall) begin
      m_we = 1'b1; m_rd = q_rd[0]; m_data = q_data[0]; pop = 1'b1;
    end else if (bus.alu_we_in && (bus.alu_rd_in != 5'd0)) begin
      m_we = 1'b1; m_rd = bus.alu_rd_in; m_data = bus.alu_data_in;
    end else if (sz > 0) begin
      m_we = 1'b1; m_rd = q_rd[0]; m_data = q_data[0]; pop = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (pop) begin
      void'(q_rd.pop_front());
      void'(q_data.pop_front());
    end
    p_acc = bus.lsu_valid_in && p_ready;
    if (p_acc && (bus.lsu_rd_in != 5'd0)) begin
      q_rd.push_back(bus.lsu_rd_in);
      q_data.push_back(bus.lsu_data_in);
    end
    if ((sz == 0) || pop) m_wait = 0;
    else if (m_wait < MAXW) m_wait = m_wait + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_idle();
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset();
    set_idle();
    bus.dec_rs1_in = 5'd5;
    rst_n = 1'b0;
    model_clear();
    #12;
    total++; if (bus.rf_we_out !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.rf_we_out); end
    total++; if (bus.rf_rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", bus.rf_rd_out); end
    total++; if (bus.rf_data_out !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.rf_data_out); end
    total++; if (bus.lsu_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.lsu_ready_out); end
    total++; if (bus.alu_stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.alu_stall_out); end
    total++; if (bus.pend_hit_out !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", bus.pend_hit_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle_lsu();
    set_idle();
    bus.lsu_valid_in = 1'b1;
    bus.lsu_rd_in    = 5'd5;
    bus.lsu_data_in  = 32'hDEADBEEF;
    tick();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", o_ready); end
    total++; if (bus.rf_we_out !== 1'b0) begin bad++; $display("FAIL idle_we_early: got %b want 0", bus.rf_we_out); end
    set_idle();
    tick();
    total++; if (bus.rf_we_out !== 1'b1) begin bad++; $display("FAIL idle_we: got %b want 1", bus.rf_we_out); end
    total++; if (bus.rf_rd_out !== 5'd5) begin bad++; $display("FAIL idle_rd: got %0d want 5", bus.rf_rd_out); end
    total++; if (bus.rf_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_data: got %h want deadbeef", bus.rf_data_out); end
    tick();
    total++; if (bus.rf_we_out !== 1'b0) begin bad++; $display("FAIL idle_we_after: got %b want 0", bus.rf_we_out); end
    total++; if (bus.rf_rd_out !== 5'd5) begin bad++; $display("FAIL idle_rd_hold: got %0d want 5", bus.rf_rd_out); end
  endtask

  task automatic test_starvation();
    int   n_alu, n7, stall_cnt;
    logic seen7;
    n_alu = 0; n7 = 0; stall_cnt = 0; seen7 = 1'b0;
    set_idle();
    bus.alu_we_in    = 1'b1;
    bus.alu_rd_in    = 5'd3;
    bus.lsu_valid_in = 1'b1;
    bus.lsu_rd_in    = 5'd7;
    bus.lsu_data_in  = 32'h7777_0007;
    for (int k = 0; k < 10; k++) begin
      bus.alu_data_in = $urandom;
      tick();
      bus.lsu_valid_in = 1'b0;
      total++; if (bus.rf_rd_out !== m_rd || bus.rf_we_out !== m_we) begin bad++; $display("FAIL starve_wr c%0d: got we=%b rd=%0d want we=%b rd=%0d", k, bus.rf_we_out, bus.rf_rd_out, m_we, m_rd); end
      total++; if (o_stall !== p_stall) begin bad++; $display("FAIL starve_stall c%0d: got %b want %b", k, o_stall, p_stall); end
      if (o_stall) begin
        stall_cnt++;
        total++; if (bus.rf_rd_out !== 5'd7) begin bad++; $display("FAIL starve_forced_rd: got %0d want 7", bus.rf_rd_out); end
      end
      if (bus.rf_we_out && bus.rf_rd_out == 5'd7) begin n7++; seen7 = 1'b1; end
      else if (k >= 1 && !seen7 && bus.rf_we_out && bus.rf_rd_out == 5'd3) n_alu++;
    end
    total++; if (stall_cnt != 1) begin bad++; $display("FAIL starve_stall_cnt: got %0d want 1", stall_cnt); end
    total++; if (n7 != 1) begin bad++; $display("FAIL starve_rd7_cnt: got %0d want 1", n7); end
    total++; if (n_alu != 4) begin bad++; $display("FAIL starve_alu_before: got %0d want 4", n_alu); end
    drain();
  endtask

  task automatic test_full();
    int          idx;
    logic        saw_block;
    logic [4:0]  order[$];
    idx = 0; saw_block = 1'b0;
    set_idle();
    bus.alu_we_in = 1'b1;
    bus.alu_rd_in = 5'd3;
    for (int k = 0; k < 25; k++) begin
      bus.alu_data_in  = $urandom;
      bus.lsu_valid_in = (idx < 3);
      bus.lsu_rd_in    = 5'(10 + idx);
      bus.lsu_data_in  = 32'hF000_0000 | 32'(idx);
      tick();
      if (p_acc) idx++;
      if (!o_ready) saw_block = 1'b1;
      total++; if (o_ready !== p_ready) begin bad++; $display("FAIL full_ready c%0d: got %b want %b", k, o_ready, p_ready); end
      total++; if (bus.rf_we_out !== m_we || bus.rf_rd_out !== m_rd || bus.rf_data_out !== m_data) begin bad++; $display("FAIL full_wr c%0d: got %b/%0d/%h want %b/%0d/%h", k, bus.rf_we_out, bus.rf_rd_out, bus.rf_data_out, m_we, m_rd, m_data); end
      if (bus.rf_we_out && bus.rf_rd_out != 5'd3) order.push_back(bus.rf_rd_out);
    end
    total++; if (!saw_block) begin bad++; $display("FAIL full_block: got ready always 1 want a 0"); end
    total++; if (order.size() != 3) begin bad++; $display("FAIL full_count: got %0d want 3", order.size()); end
    else begin
      for (int j = 0; j < 3; j++) begin
        total++; if (order[j] !== 5'(10 + j)) begin bad++; $display("FAIL full_order%0d: got %0d want %0d", j, order[j], 10 + j); end
      end
    end
    drain();
  endtask

  task automatic test_x0();
    set_idle();
    bus.lsu_valid_in = 1'b1;
    bus.lsu_rd_in    = 5'd9;
    bus.lsu_data_in  = 32'h0000_0909;
    bus.alu_we_in    = 1'b1;
    tick();
    set_idle();
    bus.alu_we_in   = 1'b1;
    bus.alu_rd_in   = 5'd0;
    bus.alu_data_in = 32'h1234_5678;
    tick();
    total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL x0_stall: got %b want 0", o_stall); end
    total++; if (bus.rf_we_out !== 1'b1 || bus.rf_rd_out !== 5'd9 || bus.rf_data_out !== 32'h0000_0909) begin bad++; $display("FAIL x0_alu_drop: got %b/%0d/%h want 1/9/00000909", bus.rf_we_out, bus.rf_rd_out, bus.rf_data_out); end
    set_idle();
    bus.lsu_valid_in = 1'b1;
    bus.lsu_rd_in    = 5'd0;
    bus.lsu_data_in  = 32'hBAD0_0000;
    tick();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL x0_lsu_ready: got %b want 1", o_ready); end
    set_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (bus.rf_we_out !== 1'b0) begin bad++; $display("FAIL x0_lsu_nowrite c%0d: got %b want 0", k, bus.rf_we_out); end
      total++; if (o_hit !== 1'b0) begin bad++; $display("FAIL x0_lsu_hit c%0d: got %b want 0", k, o_hit); end
    end
  endtask

  task automatic test_hazard();
    logic done;
    done = 1'b0;
    set_idle();
    bus.alu_we_in    = 1'b1;
    bus.alu_rd_in    = 5'd3;
    bus.lsu_valid_in = 1'b1;
    bus.lsu_rd_in    = 5'd12;
    bus.lsu_data_in  = 32'h0C0C_0C0C;
    tick();
    bus.lsu_valid_in = 1'b0;
    tick();
    total++; if (o_hit !== 1'b0) begin bad++; $display("FAIL haz_x0: got %b want 0", o_hit); end
    bus.dec_rs2_in = 5'd12;
    tick();
    total++; if (o_hit !== 1'b1) begin bad++; $display("FAIL haz_rs2: got %b want 1", o_hit); end
    for (int k = 0; k < 10 && !done; k++) begin
      tick();
      total++; if (o_hit !== p_hit) begin bad++; $display("FAIL haz_track c%0d: got %b want %b", k, o_hit, p_hit); end
      if (bus.rf_we_out && bus.rf_rd_out == 5'd12) done = 1'b1;
    end
    total++; if (!done) begin bad++; $display("FAIL haz_timeout: got no rd=12 write want one"); end
    tick();
    total++; if (o_hit !== 1'b0) begin bad++; $display("FAIL haz_after: got %b want 0", o_hit); end
    drain();
  endtask

  task automatic test_reset_midflight();
    set_idle();
    bus.alu_we_in    = 1'b1;
    bus.alu_rd_in    = 5'd3;
    bus.lsu_valid_in = 1'b1;
    bus.lsu_rd_in    = 5'd20;
    tick();
    bus.lsu_rd_in    = 5'd21;
    tick();
    bus.lsu_valid_in = 1'b0;
    bus.dec_rs1_in   = 5'd20;
    #2;
    total++; if (bus.pend_hit_out !== 1'b1) begin bad++; $display("FAIL mid_hit_before: got %b want 1", bus.pend_hit_out); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.rf_we_out !== 1'b0) begin bad++; $display("FAIL mid_we: got %b want 0", bus.rf_we_out); end
    total++; if (bus.lsu_ready_out !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", bus.lsu_ready_out); end
    total++; if (bus.pend_hit_out !== 1'b0) begin bad++; $display("FAIL mid_hit: got %b want 0", bus.pend_hit_out); end
    set_idle();
    bus.dec_rs1_in = 5'd20;
    bus.dec_rs2_in = 5'd21;
    model_clear();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (bus.rf_we_out !== 1'b0) begin bad++; $display("FAIL mid_nowrite c%0d: got we=%b rd=%0d want we=0", k, bus.rf_we_out, bus.rf_rd_out); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.alu_we_in    = ($urandom_range(0, 9) < 5);
      bus.alu_rd_in    = 5'($urandom_range(0, 7));
      bus.alu_data_in  = $urandom;
      bus.lsu_valid_in = ($urandom_range(0, 9) < 4);
      bus.lsu_rd_in    = 5'($urandom_range(0, 7));
      bus.lsu_data_in  = $urandom;
      bus.dec_rs1_in   = 5'($urandom_range(0, 7));
      bus.dec_rs2_in   = 5'($urandom_range(0, 7));
      bus.dec_rd_in    = 5'($urandom_range(0, 7));
      tick();
      total++; if (o_ready !== p_ready) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", k, o_ready, p_ready); end
      total++; if (o_stall !== p_stall) begin bad++; $display("FAIL rnd_stall c%0d: got %b want %b", k, o_stall, p_stall); end
      total++; if (o_hit !== p_hit) begin bad++; $display("FAIL rnd_hit c%0d: got %b want %b", k, o_hit, p_hit); end
      total++; if (bus.rf_we_out !== m_we) begin bad++; $display("FAIL rnd_we c%0d: got %b want %b", k, bus.rf_we_out, m_we); end
      total++; if (bus.rf_rd_out !== m_rd || bus.rf_data_out !== m_data) begin bad++; $display("FAIL rnd_wr c%0d: got %0d/%h want %0d/%h", k, bus.rf_rd_out, bus.rf_data_out, m_rd, m_data); end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_idle_lsu();
    test_starvation();
    test_full();
    test_x0();
    test_hazard();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
